// File: rtl/mest_pro_ctrl_pkg.sv
// Shared types and sizing helpers for the MEST Pro sequencer.
// State encoding plus counter-width helpers used by top and timer.
package mest_pro_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_FAULT     = 3'd4,
    ST_STEP_WAIT = 3'd5
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // bits needed to hold values 0..max_val, never less than 1
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mest_pro_wdog.sv
// Loadable down-counter with stall-style enable and zero flag.
// Ports: clk, i_reset_n, load, load_val, en -> expired (count is zero).
module mest_pro_wdog
  import mest_pro_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mest_pro_seq_ctrlr.sv
// MEST Pro fetch/decode/execute sequencer with watchdog, abort, counter.
// Optional single-step support when MEST_PRO_STEP_EN is defined.
module mest_pro_seq_ctrlr
  import mest_pro_ctrl_pkg::*;
#(
  parameter int FETCH_CYCLES  = 2,
  parameter int DECODE_CYCLES = 1,
  parameter int EXEC_TIMEOUT  = 256,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_stall,
  input  logic             i_exec_done,
  input  logic             i_end_of_code,
`ifdef MEST_PRO_STEP_EN
  input  logic             i_step_mode,
  input  logic             i_step,
  output logic             o_step_wait,
`endif
  output logic             o_idle,
  output logic             o_fetch,
  output logic             o_decode,
  output logic             o_execute,
  output logic             o_fault,
  output logic             o_all_done,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam int WD_LD_I = (EXEC_TIMEOUT > 0) ? EXEC_TIMEOUT - 1 : 0;
  localparam int TW = cnt_width(
    max3(FETCH_CYCLES - 1, DECODE_CYCLES - 1, WD_LD_I));
  localparam logic [TW-1:0] F_LD  = TW'(FETCH_CYCLES - 1);
  localparam logic [TW-1:0] D_LD  = TW'(DECODE_CYCLES - 1);
  localparam logic [TW-1:0] WD_LD = TW'(WD_LD_I);
  localparam bit WD_EN = (EXEC_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e        state;
  state_e        state_nxt;
  state_e        ret_nxt;
  logic          tmr_exp;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          retire;
  logic          start_ok;

`ifdef MEST_PRO_STEP_EN
  assign ret_nxt = i_step_mode ? ST_STEP_WAIT : ST_FETCH;
`else
  assign ret_nxt = ST_FETCH;
`endif

  always_comb begin
    state_nxt = ST_IDLE;
    if (!i_abort) begin
      unique case (state)
        ST_IDLE:
          state_nxt = i_start ? ST_FETCH : ST_IDLE;
        ST_FETCH:
          state_nxt = (!i_stall && tmr_exp) ? ST_DECODE : ST_FETCH;
        ST_DECODE:
          state_nxt = (!i_stall && tmr_exp) ? ST_EXECUTE : ST_DECODE;
        ST_EXECUTE: begin
          if (i_exec_done)
            state_nxt = i_end_of_code ? ST_IDLE : ret_nxt;
          else if (WD_EN && !i_stall && tmr_exp)
            state_nxt = ST_FAULT;
          else
            state_nxt = ST_EXECUTE;
        end
        ST_FAULT:
          state_nxt = i_start ? ST_FETCH : ST_FAULT;
`ifdef MEST_PRO_STEP_EN
        ST_STEP_WAIT:
          state_nxt = i_step ? ST_FETCH : ST_STEP_WAIT;
`endif
        default:
          state_nxt = ST_IDLE;
      endcase
    end
  end

  // one timer serves phase timing and the watchdog; reload on entry
  always_comb begin
    tmr_val = '0;
    unique case (1'b1)
      (state_nxt == ST_FETCH):   tmr_val = F_LD;
      (state_nxt == ST_DECODE):  tmr_val = D_LD;
      (state_nxt == ST_EXECUTE): tmr_val = WD_LD;
      default:                   tmr_val = '0;
    endcase
  end

  assign tmr_load = (state_nxt != state);

  mest_pro_wdog #(
    .W(TW)
  ) u_tmr (
    .clk      (clk),
    .i_reset_n(i_reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (!i_stall),
    .expired  (tmr_exp)
  );

  assign retire   = !i_abort && (state == ST_EXECUTE) && i_exec_done;
  assign start_ok = !i_abort && i_start &&
                    ((state == ST_IDLE) || (state == ST_FAULT));

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      o_all_done  <= 1'b0;
      o_instr_cnt <= '0;
    end else begin
      state      <= state_nxt;
      o_all_done <= retire && i_end_of_code;
      if (start_ok)
        o_instr_cnt <= '0;
      else if (retire && (o_instr_cnt != CNT_MAX))
        o_instr_cnt <= o_instr_cnt + 1'b1;
    end
  end

  assign o_idle    = (state == ST_IDLE);
  assign o_fetch   = (state == ST_FETCH);
  assign o_decode  = (state == ST_DECODE);
  assign o_execute = (state == ST_EXECUTE);
  assign o_fault   = (state == ST_FAULT);
`ifdef MEST_PRO_STEP_EN
  assign o_step_wait = (state == ST_STEP_WAIT);
`endif

endmodule
